// File: rtl/mvp_apb3_regs.sv
// mvp_apb3_regs: APB3 completer register bank with programmable wait states.
// Optional write protection (lock register at 0x084) under MVP_APB3_REGS_WPROT_EN.
module mvp_apb3_regs #(
    parameter int          NREG    = 8,
    parameter int          WAIT    = 1,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_si_psel,
    input  logic               i_si_penable,
    input  logic               i_si_pwrite,
    input  logic [31:0]        i_si_paddr,
    input  logic [31:0]        i_si_pwdata,
    output logic [31:0]        o_si_prdata,
    output logic               o_si_pready,
    output logic               o_si_pslverr,
    output logic [32*NREG-1:0] o_regs,
    output logic [NREG-1:0]    o_wr_pulse,
    input  logic [31:0]        i_status
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [3:0] WAIT_C = 4'(WAIT);
    localparam logic [5:0] NREG_C = 6'(NREG);

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [31:0] regs_q [NREG];
    logic [NREG-1:0] wr_pulse_q;
    logic [NREG-1:0] hit;

    logic [11:0] off;
    logic [4:0]  idx;
    logic        is_reg;
    logic        is_status;
    logic        is_lock;
    logic        lock_bit;
    logic        err;
    logic        done;
    logic        commit;
    logic [31:0] rd_val;
    logic        unused_paddr;

    assign off          = i_si_paddr[11:0];
    assign idx          = off[6:2];
    assign unused_paddr = ^i_si_paddr[31:12];

    assign is_reg = (off[1:0] == 2'b00) && (off[11:7] == 5'd0)
                  && ({1'b0, idx} < NREG_C);
    assign is_status = (off == 12'h080);

`ifdef MVP_APB3_REGS_WPROT_EN
    logic lock_q;

    assign is_lock  = (off == 12'h084);
    assign lock_bit = lock_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_q <= 1'b0;
        end else if (commit && is_lock) begin
            lock_q <= i_si_pwdata[0];
        end
    end
`else
    assign is_lock  = 1'b0;
    assign lock_bit = 1'b0;
`endif

    // Locked register writes still complete, but as errors.
    assign err = !(is_reg || is_status || is_lock)
               || (i_si_pwrite && is_status)
               || (i_si_pwrite && is_reg && lock_bit);

    assign done = (state_q == ACCESS) && i_si_psel && i_si_penable
               && (cnt_q == 4'd0);
    assign commit = done && i_si_pwrite && !err;

    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            hit[k] = is_reg && (idx == 5'(k));
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_status) rd_val = i_status;
        if (is_lock) rd_val = {31'd0, lock_bit};
        for (int k = 0; k < NREG; k++) begin
            if (hit[k]) rd_val = regs_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_si_psel && !i_si_penable) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_C;
                end
            end
            ACCESS: begin
                if (!i_si_psel) begin
                    state_d = IDLE;
                end else if (i_si_penable) begin
                    if (cnt_q == 4'd0) state_d = IDLE;
                    else cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= RST_VAL;
            wr_pulse_q <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (commit && hit[k]) regs_q[k] <= i_si_pwdata;
            end
            wr_pulse_q <= commit ? hit : '0;
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_regs
        assign o_regs[32*k +: 32] = regs_q[k];
    end

    assign o_wr_pulse   = wr_pulse_q;
    assign o_si_pready  = done;
    assign o_si_pslverr = done && err;
    assign o_si_prdata  = (done && !i_si_pwrite && !err) ? rd_val : 32'd0;

endmodule

// File: tb/tb_mvp_apb3_regs.sv
// tb_mvp_apb3_regs: three banks (WAIT 0/3/2) on a shared APB bus,
// checked against an address-map model of the register file.
module tb_mvp_apb3_regs;

    localparam int          NREG = 8;
    localparam logic [31:0] RV   = 32'hC0DE_0000;
`ifdef MVP_APB3_REGS_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] status = '0;
    int          dsel = 0;

    logic [31:0]        prdata_w [3];
    logic               pready_w [3];
    logic               pslverr_w[3];
    logic [32*NREG-1:0] regs_w   [3];
    logic [NREG-1:0]    pulse_w  [3];

    logic [31:0] mreg [3][NREG];
    bit          mlock[3];
    int          pass_cnt = 0;
    int          total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WV = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
        logic sel;
        assign sel = psel && (dsel == g);
        mvp_apb3_regs #(.NREG(NREG), .WAIT(WV), .RST_VAL(RV)) u_dut (
            .i_clk(clk),
            .i_rst(rst),
            .i_si_psel(sel),
            .i_si_penable(penable),
            .i_si_pwrite(pwrite),
            .i_si_paddr(paddr),
            .i_si_pwdata(pwdata),
            .o_si_prdata(prdata_w[g]),
            .o_si_pready(pready_w[g]),
            .o_si_pslverr(pslverr_w[g]),
            .o_regs(regs_w[g]),
            .o_wr_pulse(pulse_w[g]),
            .i_status(status)
        );
    end

    function automatic int wait_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic logic [32*NREG-1:0] mflat(int d);
        logic [32*NREG-1:0] r;
        for (int k = 0; k < NREG; k++) r[32*k +: 32] = mreg[d][k];
        return r;
    endfunction

    // Address-map rules expressed on the byte offset as plain integers.
    function automatic bit exp_err(int d, bit w, logic [31:0] a);
        int off;
        off = int'(a[11:0]);
        if (off % 4 != 0) return 1'b1;
        if (off / 4 < NREG) return w && WPROT && mlock[d];
        if (off == 128) return w;
        if (off == 132) return !WPROT;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(int d, logic [31:0] a);
        int off;
        off = int'(a[11:0]);
        if (off / 4 < NREG) return mreg[d][off/4];
        if (off == 128) return status;
        return {31'd0, mlock[d]};
    endfunction

    task automatic model_write(int d, logic [31:0] a, logic [31:0] wd);
        int off;
        off = int'(a[11:0]);
        if (off / 4 < NREG) mreg[d][off/4] = wd;
        else if (off == 132) mlock[d] = wd[0];
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < NREG; k++) mreg[d][k] = RV;
            mlock[d] = 1'b0;
        end
    endtask

    task automatic xfer(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output bit err, output int lat, output bit leak);
        @(posedge clk); #1;
        dsel = d; psel = 1'b1; penable = 1'b0;
        pwrite = w; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; leak = 1'b0; rd = 'x; err = 1'b1;
        forever begin
            @(negedge clk);
            if (pready_w[d]) begin
                rd = prdata_w[d];
                err = pslverr_w[d];
                break;
            end
            if (pslverr_w[d] || prdata_w[d] != 0) leak = 1'b1;
            lat++;
            if (lat > 40) begin
                lat = -1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (regs_w[d] !== mflat(d)) $display("FAIL reset_regs[%0d]: got %h want %h", d, regs_w[d], mflat(d));
            else pass_cnt++;
            total++;
            if ({pready_w[d], pslverr_w[d], prdata_w[d], pulse_w[d]} !== '0)
                $display("FAIL reset_out[%0d]: got %b/%b/%h/%b want 0", d, pready_w[d], pslverr_w[d], prdata_w[d], pulse_w[d]);
            else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; bit err, leak; int lat;
        xfer(0, 1'b1, 32'h004, 32'hDEAD_BEEF, rd, err, lat, leak);
        total++;
        if (lat !== 0 || err !== 1'b0) $display("FAIL zw_write: got lat %0d err %b want lat 0 err 0", lat, err);
        else pass_cnt++;
        model_write(0, 32'h004, 32'hDEAD_BEEF);
        idle();
        total++;
        if (pulse_w[0] !== 8'b0000_0010) $display("FAIL zw_pulse: got %b want 00000010", pulse_w[0]);
        else pass_cnt++;
        idle();
        total++;
        if (pulse_w[0] !== 8'b0) $display("FAIL zw_pulse_end: got %b want 00000000", pulse_w[0]);
        else pass_cnt++;
        xfer(0, 1'b0, 32'h004, 32'h0, rd, err, lat, leak);
        total++;
        if (rd !== 32'hDEAD_BEEF || lat !== 0 || err !== 1'b0)
            $display("FAIL zw_read: got %h lat %0d err %b want deadbeef lat 0 err 0", rd, lat, err);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_wait_status();
        logic [31:0] rd; bit err, leak; int lat;
        status = 32'h1234_5678;
        xfer(1, 1'b0, 32'h5500_0080, 32'h0, rd, err, lat, leak);
        total++;
        if (lat !== 3 || leak !== 1'b0) $display("FAIL ws_latency: got lat %0d leak %b want lat 3 leak 0", lat, leak);
        else pass_cnt++;
        total++;
        if (rd !== 32'h1234_5678 || err !== 1'b0) $display("FAIL ws_status: got %h err %b want 12345678 err 0", rd, err);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd; bit err, leak; int lat;
        bit          ws[3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] as[3] = '{32'h080, 32'h0A0, 32'h002};
        for (int i = 0; i < 3; i++) begin
            xfer(0, ws[i], as[i], $urandom, rd, err, lat, leak);
            total++;
            if (err !== 1'b1 || rd !== 32'h0)
                $display("FAIL err_%h: got err %b rd %h want err 1 rd 0", as[i], err, rd);
            else pass_cnt++;
            idle();
            total++;
            if (regs_w[0] !== mflat(0) || pulse_w[0] !== '0)
                $display("FAIL err_state_%h: got %h/%b want %h/0", as[i], regs_w[0], pulse_w[0], mflat(0));
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; bit err, leak; int lat;
        bit seen = 1'b0, anyp = 1'b0;
        @(posedge clk); #1;
        dsel = 2; psel = 1'b1; penable = 1'b0;
        pwrite = 1'b1; paddr = 32'h008; pwdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        seen |= pready_w[2];
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= pready_w[2];
            anyp |= |pulse_w[2];
            @(posedge clk); #1;
        end
        total++;
        if (seen || anyp || regs_w[2] !== mflat(2))
            $display("FAIL abort: got ready %b pulse %b regs %h want 0/0/%h", seen, anyp, regs_w[2], mflat(2));
        else pass_cnt++;
        xfer(2, 1'b0, 32'h008, 32'h0, rd, err, lat, leak);
        total++;
        if (rd !== mreg[2][2] || lat !== 2 || err !== 1'b0)
            $display("FAIL abort_recover: got %h lat %0d err %b want %h lat 2 err 0", rd, lat, err, mreg[2][2]);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; bit err, leak; int lat;
        xfer(1, 1'b1, 32'h000, 32'h0BAD_F00D, rd, err, lat, leak);
        model_write(1, 32'h000, 32'h0BAD_F00D);
        idle();
        @(posedge clk); #1;
        dsel = 1; psel = 1'b1; penable = 1'b0;
        pwrite = 1'b1; paddr = 32'h000; pwdata = 32'h1111_2222;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        total++;
        if ({pready_w[1], pslverr_w[1], prdata_w[1], pulse_w[1]} !== '0 || regs_w[1] !== mflat(1))
            $display("FAIL rst_mid: got %b/%b/%h/%b regs %h want 0 regs %h",
                     pready_w[1], pslverr_w[1], prdata_w[1], pulse_w[1], regs_w[1], mflat(1));
        else pass_cnt++;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        xfer(1, 1'b0, 32'h000, 32'h0, rd, err, lat, leak);
        total++;
        if (rd !== RV || lat !== 3 || err !== 1'b0)
            $display("FAIL rst_after: got %h lat %0d err %b want %h lat 3 err 0", rd, lat, err, RV);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; bit err, leak; int lat;
        int ok = 0;
        for (int i = 1; i <= 3; i++) begin
            xfer(0, 1'b1, 32'h000, 32'(i), rd, err, lat, leak);
            if (lat == 0 && err == 1'b0) ok++;
            model_write(0, 32'h000, 32'(i));
        end
        total++;
        if (ok !== 3) $display("FAIL b2b_ready: got %0d pulses want 3", ok);
        else pass_cnt++;
        idle();
        total++;
        if (regs_w[0][31:0] !== 32'd3 || pulse_w[0] !== 8'b1)
            $display("FAIL b2b_final: got %h pulse %b want 3 pulse 1", regs_w[0][31:0], pulse_w[0]);
        else pass_cnt++;
    endtask

    task automatic test_lock();
        logic [31:0] rd; bit err, leak; int lat;
`ifdef MVP_APB3_REGS_WPROT_EN
        xfer(0, 1'b1, 32'h084, 32'h1, rd, err, lat, leak);
        model_write(0, 32'h084, 32'h1);
        xfer(0, 1'b1, 32'h000, 32'h55, rd, err, lat, leak);
        total++;
        if (err !== 1'b1) $display("FAIL lock_block: got err %b want 1", err);
        else pass_cnt++;
        idle();
        total++;
        if (regs_w[0] !== mflat(0)) $display("FAIL lock_keep: got %h want %h", regs_w[0], mflat(0));
        else pass_cnt++;
        xfer(0, 1'b1, 32'h084, 32'h0, rd, err, lat, leak);
        model_write(0, 32'h084, 32'h0);
        xfer(0, 1'b1, 32'h000, 32'h55, rd, err, lat, leak);
        model_write(0, 32'h000, 32'h55);
        total++;
        if (err !== 1'b0) $display("FAIL lock_open: got err %b want 0", err);
        else pass_cnt++;
        idle();
        total++;
        if (regs_w[0][31:0] !== 32'h55) $display("FAIL lock_wr: got %h want 55", regs_w[0][31:0]);
        else pass_cnt++;
`else
        xfer(0, 1'b0, 32'h084, 32'h0, rd, err, lat, leak);
        total++;
        if (err !== 1'b1 || rd !== 32'h0) $display("FAIL nolock_rd: got err %b rd %h want 1/0", err, rd);
        else pass_cnt++;
        xfer(0, 1'b1, 32'h084, 32'h1, rd, err, lat, leak);
        total++;
        if (err !== 1'b1) $display("FAIL nolock_wr: got err %b want 1", err);
        else pass_cnt++;
        idle();
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, er; bit err, leak, w, e; int lat, d, off;
        logic [NREG-1:0] ep;
        for (int i = 0; i < 60; i++) begin
            d = $urandom_range(0, 2);
            w = 1'($urandom);
            wd = $urandom;
            status = $urandom;
            a = $urandom;
            case ($urandom_range(0, 5))
                0, 1: a[11:0] = 12'(4 * $urandom_range(0, NREG - 1));
                2: a[11:0] = 12'h080;
                3: a[11:0] = 12'h084;
                4: a[11:0] = 12'(4 * $urandom_range(NREG, 40));
                default: ;
            endcase
            e = exp_err(d, w, a);
            er = (e || w) ? 32'h0 : exp_rd(d, a);
            xfer(d, w, a, wd, rd, err, lat, leak);
            total++;
            if (err !== e || rd !== er || lat !== wait_of(d))
                $display("FAIL rand%0d d%0d a%h w%b: got err %b rd %h lat %0d want %b %h %0d",
                         i, d, a, w, err, rd, lat, e, er, wait_of(d));
            else pass_cnt++;
            ep = '0;
            off = int'(a[11:0]);
            if (w && !e) begin
                model_write(d, a, wd);
                if (off / 4 < NREG) ep[off/4] = 1'b1;
            end
            idle();
            total++;
            if (pulse_w[d] !== ep || regs_w[d] !== mflat(d))
                $display("FAIL rand%0d_state: got %b %h want %b %h", i, pulse_w[d], regs_w[d], ep, mflat(d));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_status();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_lock();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
